// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational RV ALU: decodes one request, drives registered ALU
// operands for one EXEC cycle, then holds the captured result until the response handshake.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEL_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7_5,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [DATA_W-1:0] req_imm,
  output logic [SEL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_taken,
  output logic              rsp_illegal
);

  localparam logic [SEL_W-1:0] AluAdd = SEL_W'(1);
  localparam logic [SEL_W-1:0] AluSub = SEL_W'(2);
  localparam logic [SEL_W-1:0] AluAnd = SEL_W'(3);
  localparam logic [SEL_W-1:0] AluOr  = SEL_W'(4);
  localparam logic [SEL_W-1:0] AluXor = SEL_W'(5);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_e;

  state_e            state_q, state_d;
  br_e               br_q, br_d;
  logic [SEL_W-1:0]  ctl_q, ctl_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              taken_q, taken_d;
  logic              ill_q, ill_d;

  logic              dec_legal;
  logic [SEL_W-1:0]  dec_ctl;
  logic [DATA_W-1:0] dec_b;
  br_e               dec_br;

  always_comb begin
    dec_legal = 1'b0;
    dec_ctl   = AluAdd;
    dec_b     = req_rs2;
    dec_br    = BrNone;
    case (req_opcode)
      OpReg, OpImm: begin
        dec_b     = (req_opcode == OpReg) ? req_rs2 : req_imm;
        dec_legal = 1'b1;
        case (req_funct3)
          3'b000:  dec_ctl = (req_opcode == OpReg && req_funct7_5) ? AluSub : AluAdd;
          3'b111:  dec_ctl = AluAnd;
          3'b110:  dec_ctl = AluOr;
          3'b100:  dec_ctl = AluXor;
          default: dec_legal = 1'b0;
        endcase
      end
      OpLoad, OpStore: begin
        dec_legal = 1'b1;
        dec_ctl   = AluAdd;
        dec_b     = req_imm;
      end
      OpBranch: begin
        dec_ctl = AluSub;
        dec_b   = req_rs2;
        case (req_funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_br    = BrEq;
          end
          3'b001: begin
            dec_legal = 1'b1;
            dec_br    = BrNe;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal requests skip EXEC and leave the ALU operand registers untouched.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    taken_d = taken_q;
    ill_d   = ill_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (dec_legal) begin
            ctl_d   = dec_ctl;
            a_d     = req_rs1;
            b_d     = dec_b;
            br_d    = dec_br;
            state_d = StExec;
          end else begin
            res_d   = '0;
            taken_d = 1'b0;
            ill_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StExec: begin
        res_d = alu_out;
        case (br_q)
          BrEq:    taken_d = alu_zero;
          BrNe:    taken_d = ~alu_zero;
          default: taken_d = 1'b0;
        endcase
        ill_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      br_q    <= BrNone;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign alu_ctl     = ctl_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_result  = res_q;
  assign rsp_taken   = taken_q;
  assign rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with a behavioural ALU and reference decoder.
module tb_alu_issue_ctrl;

  localparam int DW = 64;
  localparam int SW = 6;

  localparam logic [SW-1:0] AluAdd = 6'd1;
  localparam logic [SW-1:0] AluSub = 6'd2;
  localparam logic [SW-1:0] AluAnd = 6'd3;
  localparam logic [SW-1:0] AluOr  = 6'd4;
  localparam logic [SW-1:0] AluXor = 6'd5;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic          clk, rst_n;
  logic          req_valid, req_ready;
  logic [6:0]    req_opcode;
  logic [2:0]    req_funct3;
  logic          req_funct7_5;
  logic [DW-1:0] req_rs1, req_rs2, req_imm;
  logic [SW-1:0] alu_ctl;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_taken, rsp_illegal;

  alu_issue_ctrl #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
  );

  // External combinational ALU
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      AluAdd:  alu_out = alu_a + alu_b;
      AluSub:  alu_out = alu_a - alu_b;
      AluAnd:  alu_out = alu_a & alu_b;
      AluOr:   alu_out = alu_a | alu_b;
      AluXor:  alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic          taken;
    logic          ill;
    logic [SW-1:0] ctl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rr_mode = 2;  // 0 random, 1 hold low, 2 hold high
  bit   busy = 0, started = 0, hs = 0;
  logic [SW-1:0] last_ctl = '0;
  logic [DW-1:0] last_a = '0, last_b = '0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  // Reference decode/execute straight from the instruction-level rules.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                                input logic [DW-1:0] imm, output logic legal,
                                output logic [SW-1:0] ctl, output logic [DW-1:0] b,
                                output logic [DW-1:0] res, output logic taken);
    legal = 1'b0; ctl = AluAdd; b = '0; res = '0; taken = 1'b0;
    if (op == OpReg || op == OpImm) begin
      b = (op == OpReg) ? rs2 : imm;
      legal = 1'b1;
      if (f3 == 3'd0)      ctl = (op == OpReg && f75) ? AluSub : AluAdd;
      else if (f3 == 3'd7) ctl = AluAnd;
      else if (f3 == 3'd6) ctl = AluOr;
      else if (f3 == 3'd4) ctl = AluXor;
      else legal = 1'b0;
    end else if (op == OpLoad || op == OpStore) begin
      legal = 1'b1; ctl = AluAdd; b = imm;
    end else if (op == OpBranch && f3 <= 3'd1) begin
      legal = 1'b1; ctl = AluSub; b = rs2;
      taken = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
    end
    if (legal) begin
      case (ctl)
        AluAdd:  res = rs1 + b;
        AluSub:  res = rs1 - b;
        AluAnd:  res = rs1 & b;
        AluOr:   res = rs1 | b;
        default: res = rs1 ^ b;
      endcase
    end else begin
      taken = 1'b0;
    end
  endfunction

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                       input logic [DW-1:0] imm, input bit use_exp,
                       input logic [DW-1:0] xres, input logic xtaken, input logic xill);
    exp_t e;
    logic legal, taken;
    logic [SW-1:0] ctl;
    logic [DW-1:0] b, res;
    int n;
    model(op, f3, f75, rs1, rs2, imm, legal, ctl, b, res, taken);
    e.res = use_exp ? xres : res;
    e.taken = use_exp ? xtaken : taken;
    e.ill = use_exp ? xill : ~legal;
    if (legal) begin
      last_ctl = ctl; last_a = rs1; last_b = b;
    end
    e.ctl = last_ctl; e.a = last_a; e.b = last_b;
    e.lat = legal ? 2 : 1;
    @(posedge clk);
    #1;
    req_opcode = op; req_funct3 = f3; req_funct7_5 = f75;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: req_ready got 0 want 1 after %0d cycles", n);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rs1 = {$urandom(), $urandom()};
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: pending got %0d want 0", sb.size());
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 2) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops an expectation when the DUT goes busy, checks operands, latency and payload.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; started = 0; hs = 0;
      end else begin
        if (hs) begin
          chk("idle_after_handshake", {63'd0, req_ready}, 64'd1);
          hs = 0;
        end
        if (req_ready) begin
          chk("valid_while_idle", {63'd0, rsp_valid}, 64'd0);
        end else begin
          if (!busy) begin
            if (sb.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL spurious_busy: queue got 0 entries want 1");
            end else begin
              cur = sb.pop_front();
              busy = 1;
            end
          end
          if (busy) begin
            chk("alu_ctl", {58'd0, alu_ctl}, {58'd0, cur.ctl});
            chk("alu_a", alu_a, cur.a);
            chk("alu_b", alu_b, cur.b);
            if (rsp_valid) begin
              if (!started) begin
                started = 1;
                chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
              end
              chk("rsp_result", rsp_result, cur.res);
              chk("rsp_taken", {63'd0, rsp_taken}, {63'd0, cur.taken});
              chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, cur.ill});
              if (rsp_ready) begin
                hs = 1; busy = 0; started = 0;
              end
            end else if (cyc - cur.acc >= cur.lat) begin
              chk("late_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_rsp_result"}, rsp_result, 64'd0);
    chk({tag, "_rsp_taken"}, {63'd0, rsp_taken}, 64'd0);
    chk({tag, "_rsp_illegal"}, {63'd0, rsp_illegal}, 64'd0);
    chk({tag, "_alu_ctl"}, {58'd0, alu_ctl}, 64'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
  endtask

  initial begin
    logic [6:0] op;
    logic [DW-1:0] r1, r2;
    rst_n = 1'b0;
    req_valid = 1'b0; req_opcode = '0; req_funct3 = '0; req_funct7_5 = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    issue(OpReg, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 1, 64'd12, 1'b0, 1'b0);
    issue(OpReg, 3'b000, 1'b1, 64'd0, 64'd1, 64'd0, 1, {DW{1'b1}}, 1'b0, 1'b0);
    issue(OpImm, 3'b100, 1'b1, 64'hF0, 64'd9, 64'hFF, 1, 64'h0F, 1'b0, 1'b0);
    issue(OpBranch, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'd0, 1, 64'd0, 1'b1, 1'b0);
    issue(OpBranch, 3'b001, 1'b0, 64'h1234, 64'h1234, 64'd0, 1, 64'd0, 1'b0, 1'b0);
    issue(OpBranch, 3'b001, 1'b0, 64'd1, 64'd2, 64'd0, 1, {DW{1'b1}}, 1'b1, 1'b0);
    issue(7'b1110011, 3'b000, 1'b0, 64'd3, 64'd4, 64'd5, 1, 64'd0, 1'b0, 1'b1);
    issue(OpReg, 3'b001, 1'b0, 64'd3, 64'd4, 64'd5, 1, 64'd0, 1'b0, 1'b1);
    issue(OpLoad, 3'b010, 1'b0, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'hFF8, 1'b0, 1'b0);
    wait_idle();

    // Backpressure: response held for 5 cycles while a second request waits.
    rr_mode = 1;
    issue(OpStore, 3'b011, 1'b0, 64'd40, 64'd0, 64'd2, 1, 64'd42, 1'b0, 1'b0);
    fork
      issue(OpImm, 3'b110, 1'b0, 64'hA0, 64'd0, 64'h0B, 1, 64'hAB, 1'b0, 1'b0);
      begin
        int n = 0;
        while (!rsp_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        rr_mode = 2;
      end
    join
    wait_idle();

    // Reset in EXEC discards the operation.
    issue(OpReg, 3'b111, 1'b0, 64'hFF, 64'h0F, 64'd0, 0, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    last_ctl = '0; last_a = '0; last_b = '0;
    #1;
    chk_reset_outputs("midop_reset");
    repeat (3) begin
      @(negedge clk);
      chk("rsp_valid_in_reset", {63'd0, rsp_valid}, 64'd0);
    end
    rst_n = 1'b1;
    issue(OpReg, 3'b000, 1'b0, 64'd3, 64'd4, 64'd0, 1, 64'd7, 1'b0, 1'b0);
    wait_idle();

    rr_mode = 0;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 6))
        0:       op = OpReg;
        1:       op = OpImm;
        2:       op = OpLoad;
        3:       op = OpStore;
        4:       op = OpBranch;
        default: op = 7'($urandom());
      endcase
      r1 = {$urandom(), $urandom()};
      r2 = ($urandom_range(0, 3) == 0) ? r1 : {$urandom(), $urandom()};
      issue(op, 3'($urandom()), 1'($urandom()), r1, r2, {$urandom(), $urandom()},
            0, 64'd0, 1'b0, 1'b0);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
